muldiv_hilo_sched: RTL and testbench
====================================

// Module: muldiv_hilo_sched
// PURPOSE
//  Sequences the shared multiply and divide units and owns the architectural HI/LO registers.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the execute stage via a valid/ready handshake.
//  Launches one mult/div at a time and captures its result into HI/LO.
//  Interlocks HI/LO readers and writers against an in-flight operation.
//  Sits between execute-stage decode and the Mult/Div units; op_ready feeds the pipeline stall.
// PARAMETERS
//  WIDTH    32  datapath width of operands, HI and LO
//  TIMEOUT  64  max cycles to wait for a unit's validOut before abandoning the op (>=2)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  op_valid     in   1      execute stage presents an op
//  op_code      in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
//  op_a         in   WIDTH  SrcA (rs)
//  op_b         in   WIDTH  SrcB (rt)
//  op_ready     out  1      op accepted this cycle when op_valid&op_ready; stall = op_valid&~op_ready
//  flush        in   1      abandon in-flight op (branch/exception squash)
//  mf_data      out  WIDTH  MFHI/MFLO result, valid in the accept cycle
//  mul_validIn  out  1      one-cycle start pulse to multiplier (registered)
//  mul_sign     out  1      1=signed; held while multiplier busy
//  mul_validOut in   1      multiplier result valid
//  mul_hi/lo    in   WIDTH  multiplier result
//  div_validIn  out  1      one-cycle start pulse to divider (registered)
//  div_sign     out  1      1=signed; held while divider busy
//  div_validOut in   1      divider result valid
//  div_hi/lo    in   WIDTH  divider result (hi=remainder, lo=quotient)
//  unit_a/b     out  WIDTH  latched operands to both units, stable from start until completion
//  hi/lo        out  WIDTH  architectural HI/LO (debug/trace)
//  div_zero     out  1      one-cycle pulse: DIV/DIVU accepted with op_b==0
//  timeout_err  out  1      one-cycle pulse: unit failed to respond within TIMEOUT
// BEHAVIOUR
//  Reset (async): state=IDLE, hi=lo=0, unit_a/b=0, *_validIn=0, *_sign=0, div_zero=timeout_err=0, cnt=0.
//  States: IDLE, MUL_BUSY, DIV_BUSY, DRAIN.
//  op_ready = (state==IDLE) & ~flush. mf_data = (op_code==7) ? lo : hi, combinational.
//  IDLE, op accepted:
//   MULT/MULTU -> latch unit_a/b and mul_sign; mul_validIn=1 next cycle; ->MUL_BUSY.
//   DIV/DIVU with op_b!=0 -> same via div_*; ->DIV_BUSY.
//   DIV/DIVU with op_b==0 -> no start; hi/lo unchanged; div_zero=1 next cycle; stay IDLE.
//   MTHI/MTLO -> hi/lo <= op_a at the edge. MFHI/MFLO -> read only; state unchanged.
//  *_validIn high exactly one cycle, the first cycle of MUL_BUSY/DIV_BUSY.
//  MUL_BUSY/DIV_BUSY:
//   cnt increments each cycle. Owning unit's validOut=1 -> hi/lo <= unit hi/lo; ->IDLE.
//   Earliest reaccept is the cycle after validOut (min mult latency = 1 cycle after start).
//   Non-owning unit's validOut is ignored.
//   cnt==TIMEOUT-1 without validOut -> timeout_err pulse; hi/lo unchanged; ->IDLE.
//  flush: in IDLE no effect; any op presented that cycle is not accepted.
//   In BUSY with owning validOut same cycle -> result discarded; ->IDLE.
//   In BUSY otherwise -> DRAIN (owner remembered).
//  DRAIN: owner validOut or timeout -> ->IDLE, hi/lo never written.
//   Prevents a stale result landing on a later op.
//  validOut in IDLE (e.g. after reset mid-op) is ignored.
//  cnt clears on every state entry. Widths: no extension; hi/lo exactly WIDTH bits.
// TESTING
//  MULT a=0xFFFFFFFE b=3, mult validOut 4 cycles after start
//   -> 1-cycle mul_validIn, mul_sign=1; op_ready=0 for 5 cycles; hi=0xFFFFFFFF lo=0xFFFFFFFA.
//  MTHI 0x1234 then MFHI -> mf_data=0x1234 in accept cycle;
//   MFLO issued while DIV_BUSY stalls until cycle after div_validOut, then returns new lo.
//  DIVU a=7 b=0 -> no div_validIn, div_zero pulse, hi/lo unchanged, op_ready stays 1.
//  MULTU started, flush 2 cycles later, new MULT presented
//   -> DRAIN until validOut, first result discarded (hi/lo unchanged), new MULT then accepted.
//  Divider never responds, TIMEOUT=8 -> timeout_err pulse 8 cycles after entering DIV_BUSY; IDLE; hi/lo unchanged.
//  reset asserted mid MUL_BUSY, stray mul_validOut afterwards -> hi=lo=0, state IDLE, op_ready=1.

Source files
------------

// File: rtl/muldiv_hilo_sched_if.sv
// Execute-stage op handshake, HI/LO debug view and the shared mult/div unit bundle.
// The slave modport is the scheduler's view; master is the execute stage and the units.
interface muldiv_hilo_sched_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_ready;
  logic             flush;
  logic [WIDTH-1:0] mf_data;

  logic             mul_validIn;
  logic             mul_sign;
  logic             mul_validOut;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  logic             div_validIn;
  logic             div_sign;
  logic             div_validOut;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  logic [WIDTH-1:0] unit_a;
  logic [WIDTH-1:0] unit_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  logic             timeout_err;

  modport slave (
    input  op_valid, op_code, op_a, op_b, flush,
    input  mul_validOut, mul_hi, mul_lo, div_validOut, div_hi, div_lo,
    output op_ready, mf_data, mul_validIn, mul_sign, div_validIn, div_sign,
    output unit_a, unit_b, hi, lo, div_zero, timeout_err
  );

  modport master (
    output op_valid, op_code, op_a, op_b, flush,
    output mul_validOut, mul_hi, mul_lo, div_validOut, div_hi, div_lo,
    input  op_ready, mf_data, mul_validIn, mul_sign, div_validIn, div_sign,
    input  unit_a, unit_b, hi, lo, div_zero, timeout_err
  );
endinterface

// File: rtl/muldiv_hilo_sched.sv
// HI/LO owner and one-at-a-time sequencer for the shared multiplier and divider.
// Interlocks HI/LO access against the in-flight op and drains squashed ops safely.
module muldiv_hilo_sched #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                clk,
  input logic                reset,
  muldiv_hilo_sched_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;
  localparam logic [2:0] OpMflo  = 3'd7;

  typedef enum logic [1:0] {StIdle, StMulBusy, StDivBusy, StDrain} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]  unit_a_q, unit_a_d, unit_b_q, unit_b_d;
  logic              mul_sign_q, mul_sign_d, div_sign_q, div_sign_d;
  logic              owner_div_q, owner_div_d;
  logic              mul_start_q, mul_start_d, div_start_q, div_start_d;
  logic              div_zero_q, div_zero_d, timeout_q, timeout_d;

  logic              op_ready;
  logic              accept;
  logic              owner_done;
  logic              cnt_expired;
  logic [WIDTH-1:0]  owner_hi, owner_lo;

  assign op_ready    = (state_q == StIdle) & ~bus.flush;
  assign accept      = bus.op_valid & op_ready;
  assign owner_done  = owner_div_q ? bus.div_validOut : bus.mul_validOut;
  assign owner_hi    = owner_div_q ? bus.div_hi : bus.mul_hi;
  assign owner_lo    = owner_div_q ? bus.div_lo : bus.mul_lo;
  assign cnt_expired = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    unit_a_d    = unit_a_q;
    unit_b_d    = unit_b_q;
    mul_sign_d  = mul_sign_q;
    div_sign_d  = div_sign_q;
    owner_div_d = owner_div_q;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;
    div_zero_d  = 1'b0;
    timeout_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          unique case (bus.op_code)
            OpMult, OpMultu: begin
              unit_a_d    = bus.op_a;
              unit_b_d    = bus.op_b;
              mul_sign_d  = (bus.op_code == OpMult);
              owner_div_d = 1'b0;
              mul_start_d = 1'b1;
              state_d     = StMulBusy;
            end
            OpDiv, OpDivu: begin
              if (bus.op_b == '0) begin
                div_zero_d = 1'b1;
              end else begin
                unit_a_d    = bus.op_a;
                unit_b_d    = bus.op_b;
                div_sign_d  = (bus.op_code == OpDiv);
                owner_div_d = 1'b1;
                div_start_d = 1'b1;
                state_d     = StDivBusy;
              end
            end
            OpMthi:  hi_d = bus.op_a;
            OpMtlo:  lo_d = bus.op_a;
            default: ;
          endcase
        end
      end
      StMulBusy, StDivBusy: begin
        cnt_d = cnt_q + CntW'(1);
        if (owner_done) begin
          // A flush in the completion cycle squashes the result.
          if (!bus.flush) begin
            hi_d = owner_hi;
            lo_d = owner_lo;
          end
          state_d = StIdle;
          cnt_d   = '0;
        end else if (bus.flush) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else if (cnt_expired) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
          cnt_d     = '0;
        end
      end
      StDrain: begin
        // Wait out the squashed op so its result cannot land on a later one.
        cnt_d = cnt_q + CntW'(1);
        if (owner_done) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_expired) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      unit_a_q    <= '0;
      unit_b_q    <= '0;
      mul_sign_q  <= 1'b0;
      div_sign_q  <= 1'b0;
      owner_div_q <= 1'b0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      div_zero_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      unit_a_q    <= unit_a_d;
      unit_b_q    <= unit_b_d;
      mul_sign_q  <= mul_sign_d;
      div_sign_q  <= div_sign_d;
      owner_div_q <= owner_div_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
      div_zero_q  <= div_zero_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.op_ready    = op_ready;
  assign bus.mf_data     = (bus.op_code == OpMflo) ? lo_q : hi_q;
  assign bus.mul_validIn = mul_start_q;
  assign bus.mul_sign    = mul_sign_q;
  assign bus.div_validIn = div_start_q;
  assign bus.div_sign    = div_sign_q;
  assign bus.unit_a      = unit_a_q;
  assign bus.unit_b      = unit_b_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_zero    = div_zero_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_muldiv_hilo_sched.sv
// Directed and randomized bench for muldiv_hilo_sched; the bench plays both arithmetic units
// and keeps its own HI/LO model computed with plain arithmetic.
module tb_muldiv_hilo_sched;
  localparam int unsigned W  = 32;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  muldiv_hilo_sched_if #(.WIDTH(W)) bus ();

  muldiv_hilo_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_a     = a;
    bus.op_b     = b;
  endtask

  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit s);
    longint pa, pb;
    if (s) begin
      pa = $signed(a);
      pb = $signed(b);
      return 64'(pa * pb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit s);
    int sa, sb;
    logic [W-1:0] q, r;
    if (s) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  initial begin
    logic [2:0]   code;
    logic [W-1:0] a, b;
    logic [63:0]  res;
    bit           isdiv, sgn;
    int           lat, busy_cnt;

    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
    bus.mul_validOut = 1'b0; bus.mul_hi = '0; bus.mul_lo = '0;
    bus.div_validOut = 1'b0; bus.div_hi = '0; bus.div_lo = '0;

    // Reset state
    tick();
    tick();
    sample();
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_ready", bus.op_ready, 1);
    chk("rst_mul_vin", bus.mul_validIn, 0);
    chk("rst_div_vin", bus.div_validIn, 0);
    chk("rst_signs", {bus.mul_sign, bus.div_sign}, 0);
    chk("rst_units", {bus.unit_a, bus.unit_b}, 0);
    chk("rst_pulses", {bus.div_zero, bus.timeout_err}, 0);
    tick();
    reset = 1'b0;

    // MULT -2 * 3, result 4 cycles after start
    tick();
    drive_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    sample();
    chk("m1_ready_idle", bus.op_ready, 1);
    tick();
    bus.op_valid = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin
        res = ref_mul(32'hFFFF_FFFE, 32'd3, 1'b1);
        bus.mul_validOut = 1'b1;
        bus.mul_hi = res[63:32];
        bus.mul_lo = res[31:0];
      end
      sample();
      if (i == 1) begin
        chk("m1_vin_first", bus.mul_validIn, 1);
        chk("m1_sign", bus.mul_sign, 1);
        chk("m1_unit_a", bus.unit_a, 32'hFFFF_FFFE);
      end else begin
        chk("m1_vin_once", bus.mul_validIn, 0);
      end
      if (!bus.op_ready) busy_cnt++;
      tick();
    end
    bus.mul_validOut = 1'b0;
    sample();
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFFA;
    chk("m1_stall_cycles", busy_cnt, 5);
    chk("m1_ready_after", bus.op_ready, 1);
    chk("m1_hi", bus.hi, m_hi);
    chk("m1_lo", bus.lo, m_lo);

    // MTHI then MFHI; MFLO stalled behind DIVU
    tick();
    drive_op(3'd4, 32'h1234, 32'h0);
    tick();
    drive_op(3'd6, 32'h0, 32'h0);
    m_hi = 32'h1234;
    sample();
    chk("mfhi_data", bus.mf_data, m_hi);
    chk("mfhi_ready", bus.op_ready, 1);
    tick();
    drive_op(3'd3, 32'd100, 32'd7);
    tick();
    drive_op(3'd7, 32'h0, 32'h0);
    sample();
    chk("divu_vin", bus.div_validIn, 1);
    chk("divu_sign", bus.div_sign, 0);
    chk("mflo_stall1", bus.op_ready, 0);
    tick();
    sample();
    chk("mflo_stall2", bus.op_ready, 0);
    tick();
    bus.div_validOut = 1'b1;
    bus.div_hi = 32'd2;
    bus.div_lo = 32'd14;
    sample();
    chk("mflo_stall3", bus.op_ready, 0);
    tick();
    bus.div_validOut = 1'b0;
    m_hi = 32'd2;
    m_lo = 32'd14;
    sample();
    chk("mflo_ready", bus.op_ready, 1);
    chk("mflo_data", bus.mf_data, m_lo);
    chk("divu_hi", bus.hi, m_hi);
    tick();
    bus.op_valid = 1'b0;

    // DIVU by zero
    tick();
    drive_op(3'd3, 32'd7, 32'd0);
    tick();
    bus.op_valid = 1'b0;
    sample();
    chk("dz_pulse", bus.div_zero, 1);
    chk("dz_no_start", bus.div_validIn, 0);
    chk("dz_ready", bus.op_ready, 1);
    chk("dz_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    tick();
    sample();
    chk("dz_pulse_end", bus.div_zero, 0);

    // MULTU squashed by flush, new MULT waits for drain
    tick();
    drive_op(3'd1, 32'd5, 32'd6);
    tick();
    bus.op_valid = 1'b0;
    sample();
    chk("fl_sign", bus.mul_sign, 0);
    tick();
    tick();
    bus.flush = 1'b1;
    drive_op(3'd0, 32'd3, 32'd4);
    sample();
    chk("fl_ready_flush", bus.op_ready, 0);
    tick();
    bus.flush = 1'b0;
    sample();
    chk("fl_drain1", bus.op_ready, 0);
    tick();
    tick();
    bus.mul_validOut = 1'b1;
    bus.mul_hi = 32'd0;
    bus.mul_lo = 32'd30;
    sample();
    chk("fl_drain3", bus.op_ready, 0);
    tick();
    bus.mul_validOut = 1'b0;
    sample();
    chk("fl_discard", {bus.hi, bus.lo}, {m_hi, m_lo});
    chk("fl_ready_after", bus.op_ready, 1);
    tick();
    bus.op_valid = 1'b0;
    sample();
    chk("fl_new_start", bus.mul_validIn, 1);
    chk("fl_new_units", {bus.unit_a, bus.unit_b}, {32'd3, 32'd4});
    tick();
    bus.mul_validOut = 1'b1;
    bus.mul_hi = 32'd0;
    bus.mul_lo = 32'd12;
    tick();
    bus.mul_validOut = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd12;
    sample();
    chk("fl_new_result", {bus.hi, bus.lo}, {m_hi, m_lo});

    // Divider never answers
    tick();
    drive_op(3'd2, 32'd9, 32'd2);
    tick();
    bus.op_valid = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      sample();
      chk($sformatf("to_err_k%0d", k), bus.timeout_err, (k == 8) ? 1 : 0);
      chk($sformatf("to_ready_k%0d", k), bus.op_ready, (k >= 8) ? 1 : 0);
      tick();
    end
    sample();
    chk("to_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

    // Reset mid MUL_BUSY, stray validOut afterwards
    tick();
    drive_op(3'd4, 32'hABCD, 32'h0);
    tick();
    drive_op(3'd0, 32'd7, 32'd9);
    tick();
    bus.op_valid = 1'b0;
    tick();
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    sample();
    chk("mr_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    chk("mr_ready", bus.op_ready, 1);
    chk("mr_unit_a", bus.unit_a, 0);
    tick();
    reset = 1'b0;
    bus.mul_validOut = 1'b1;
    bus.mul_hi = 32'hDEAD;
    bus.mul_lo = 32'hBEEF;
    tick();
    bus.mul_validOut = 1'b0;
    sample();
    chk("mr_stray_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    chk("mr_stray_ready", bus.op_ready, 1);

    // Randomized ops against the model
    for (int n = 0; n < 80; n++) begin
      code = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ((code == 3'd2 || code == 3'd3) && $urandom_range(0, 3) == 0) b = '0;
      if (code == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      tick();
      drive_op(code, a, b);
      sample();
      chk("rnd_ready", bus.op_ready, 1);
      if (code >= 3'd6) chk("rnd_mf", bus.mf_data, (code == 3'd7) ? m_lo : m_hi);
      tick();
      bus.op_valid = 1'b0;
      if (code <= 3'd1 || (code <= 3'd3 && b != '0)) begin
        isdiv = (code >= 3'd2);
        sgn   = (code == 3'd0 || code == 3'd2);
        res   = isdiv ? ref_div(a, b, sgn) : ref_mul(a, b, sgn);
        // The idle unit raising validOut must be ignored.
        if (isdiv) bus.mul_validOut = 1'b1;
        else bus.div_validOut = 1'b1;
        sample();
        chk("rnd_start", isdiv ? bus.div_validIn : bus.mul_validIn, 1);
        chk("rnd_sign", isdiv ? bus.div_sign : bus.mul_sign, sgn);
        chk("rnd_units", {bus.unit_a, bus.unit_b}, {a, b});
        lat = $urandom_range(1, 5);
        for (int j = 0; j < lat; j++) begin
          tick();
          bus.mul_validOut = 1'b0;
          bus.div_validOut = 1'b0;
        end
        if (isdiv) begin
          bus.div_validOut = 1'b1; bus.div_hi = res[63:32]; bus.div_lo = res[31:0];
        end else begin
          bus.mul_validOut = 1'b1; bus.mul_hi = res[63:32]; bus.mul_lo = res[31:0];
        end
        sample();
        chk("rnd_busy", bus.op_ready, 0);
        tick();
        bus.mul_validOut = 1'b0;
        bus.div_validOut = 1'b0;
        m_hi = res[63:32];
        m_lo = res[31:0];
        sample();
      end else begin
        sample();
        if (code == 3'd2 || code == 3'd3) chk("rnd_dz", bus.div_zero, 1);
        if (code == 3'd4) m_hi = a;
        if (code == 3'd5) m_lo = a;
      end
      chk("rnd_hi", bus.hi, m_hi);
      chk("rnd_lo", bus.lo, m_lo);
      chk("rnd_ready_end", bus.op_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
